// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display controller: glyph table,
// blank/dash patterns, FSM state encoding and the double-dabble threshold.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Active-low gfedcba patterns, index 15 (F) first down to index 0.
   localparam logic [15:0][6:0] SEG_GLYPHS = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

   localparam logic [3:0] BCD_ADD3_MIN = 4'd5;

endpackage

// File: rtl/seg_glyph.sv
// Combinational nibble to active-low seven-segment decoder with a blank override.
module seg_glyph
   import seg_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = blank ? SEG_BLANK : SEG_GLYPHS[digit];
   end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: captures a value on load, renders it
// as hex or as decimal via a sequential double-dabble, with blanking and overflow.
module seg_display_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS = 6,
   parameter int WIDTH  = 20
)
(
   input  logic                  mem_clk,
   input  logic                  resetn,
   input  logic [WIDTH-1:0]      value,
   input  logic                  load,
   input  logic                  dec_mode,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   state_t              state;
   logic [WIDTH-1:0]    bin_reg;
   logic [BW-1:0]       bcd_reg;
   logic [BW-1:0]       bcd_adj;
   logic [BW-1:0]       hex_digits;
   logic [BW-1:0]       disp_digits;
   logic                sticky_ovf;
   logic                dec_r;
   logic                blank_r;
   logic [CW-1:0]       shift_cnt;
   logic                hex_ovf;
   logic                disp_ovf;
   logic [DIGITS-1:0]   digit_blank;
   logic [7*DIGITS-1:0] glyphs;
   logic [7*DIGITS-1:0] next_seg;

   // Double-dabble correction applied to every BCD digit before each shift.
   always_comb begin
      bcd_adj = bcd_reg;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_reg[4*i +: 4] >= BCD_ADD3_MIN) begin
            bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
         end
      end
   end

   generate
      if (WIDTH > BW) begin : g_hex_wide
         assign hex_digits = bin_reg[BW-1:0];
         assign hex_ovf    = |bin_reg[WIDTH-1:BW];
      end else if (WIDTH == BW) begin : g_hex_exact
         assign hex_digits = bin_reg;
         assign hex_ovf    = 1'b0;
      end else begin : g_hex_narrow
         assign hex_digits = {{(BW-WIDTH){1'b0}}, bin_reg};
         assign hex_ovf    = 1'b0;
      end
   endgenerate

   assign disp_digits = dec_r ? bcd_reg : hex_digits;
   assign disp_ovf    = dec_r ? sticky_ovf : hex_ovf;

   // Blank every digit above the most significant nonzero one; digit 0 always shows.
   always_comb begin
      logic all_zero;
      all_zero    = 1'b1;
      digit_blank = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero       = all_zero && (disp_digits[4*i +: 4] == 4'd0);
         digit_blank[i] = blank_r && (i != 0) && all_zero;
      end
   end

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_digit
         seg_glyph u_glyph (
            .digit (disp_digits[4*g +: 4]),
            .blank (digit_blank[g]),
            .seg   (glyphs[7*g +: 7])
         );
         assign next_seg[7*g +: 7] = disp_ovf ? SEG_DASH : glyphs[7*g +: 7];
      end
   endgenerate

   assign busy = (state != IDLE);

   // Control FSM with capture, shift datapath and registered display outputs.
   always_ff @(posedge mem_clk) begin
      if (!resetn) begin
         state      <= IDLE;
         seg        <= '1;
         done       <= 1'b0;
         overflow   <= 1'b0;
         bin_reg    <= '0;
         bcd_reg    <= '0;
         sticky_ovf <= 1'b0;
         dec_r      <= 1'b0;
         blank_r    <= 1'b0;
         shift_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  bin_reg    <= value;
                  dec_r      <= dec_mode;
                  blank_r    <= blank_lz;
                  bcd_reg    <= '0;
                  sticky_ovf <= 1'b0;
                  shift_cnt  <= '0;
                  state      <= dec_mode ? SHIFT : UPDATE;
               end
            end
            SHIFT: begin
               bcd_reg    <= {bcd_adj[BW-2:0], bin_reg[WIDTH-1]};
               bin_reg    <= bin_reg << 1;
               sticky_ovf <= sticky_ovf | bcd_adj[BW-1];
               shift_cnt  <= shift_cnt + CW'(1);
               if (shift_cnt == CW'(WIDTH - 1)) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               seg      <= next_seg;
               overflow <= disp_ovf;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl (DIGITS=6, WIDTH=20).
module tb_seg_display_ctrl;

   localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
   localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
   localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110;
   localparam logic [6:0] BL = 7'b1111111, DS = 7'b0111111;

   logic        mem_clk;
   logic        resetn;
   logic [19:0] value;
   logic        load;
   logic        dec_mode;
   logic        blank_lz;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [41:0] seg;

   int checks   = 0;
   int failures = 0;

   seg_display_ctrl #(.DIGITS(6), .WIDTH(20)) dut (
      .mem_clk  (mem_clk),
      .resetn   (resetn),
      .value    (value),
      .load     (load),
      .dec_mode (dec_mode),
      .blank_lz (blank_lz),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .seg      (seg)
   );

   initial mem_clk = 1'b0;
   always #5 mem_clk = ~mem_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic apply_stimulus(input logic [19:0] v, input logic d, input logic b);
      @(negedge mem_clk);
      value    = v;
      dec_mode = d;
      blank_lz = b;
      load     = 1'b1;
      @(negedge mem_clk);
      load     = 1'b0;
   endtask

   // Called at the first falling edge after the accepting edge; stops on done or budget.
   task automatic wait_done(output int lat, output int bcyc);
      lat  = 0;
      bcyc = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcyc++;
         @(negedge mem_clk);
         lat++;
      end
   endtask

   task automatic check_output(input string tag, input logic [41:0] exp_seg, input logic exp_ovf,
                               input int exp_lat);
      int lat;
      int bcyc;
      wait_done(lat, bcyc);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, bcyc, exp_lat);
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_seg"}, seg, exp_seg);
      check({tag, "_overflow"}, overflow, exp_ovf);
      @(negedge mem_clk);
      check({tag, "_done_fall"}, done, 1'b0);
      check({tag, "_busy_idle"}, busy, 1'b0);
   endtask

   initial begin
      int          pulses;
      logic [41:0] snap_seg;

      $display("[TB] seg_display_ctrl directed test start");
      resetn   = 1'b0;
      value    = '0;
      load     = 1'b0;
      dec_mode = 1'b0;
      blank_lz = 1'b0;
      repeat (2) @(posedge mem_clk);
      @(negedge mem_clk);
      check("reset_seg", seg, {42{1'b1}});
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_overflow", overflow, 1'b0);
      resetn = 1'b1;

      apply_stimulus(20'hABCDE, 1'b0, 1'b0);
      check("hex_busy_e0", busy, 1'b1);
      check_output("hex_abcde", {G0, GA, GB, GC, GD, GE}, 1'b0, 1);

      apply_stimulus(20'd987654, 1'b1, 1'b0);
      check_output("dec_987654", {G9, G8, G7, G6, G5, G4}, 1'b0, 21);

      apply_stimulus(20'd42, 1'b1, 1'b1);
      check_output("dec_42_lz", {BL, BL, BL, BL, G4, G2}, 1'b0, 21);

      apply_stimulus(20'd0, 1'b1, 1'b1);
      check_output("dec_0_lz", {BL, BL, BL, BL, BL, G0}, 1'b0, 21);

      apply_stimulus(20'd1000000, 1'b1, 1'b1);
      check_output("dec_ovf", {DS, DS, DS, DS, DS, DS}, 1'b1, 21);

      apply_stimulus(20'd5, 1'b1, 1'b0);
      check_output("dec_5_clear", {G0, G0, G0, G0, G0, G5}, 1'b0, 21);

      // A second load during the shift phase must not be queued or restart anything.
      apply_stimulus(20'd123456, 1'b1, 1'b0);
      pulses   = 0;
      snap_seg = '0;
      for (int i = 0; i < 30; i++) begin
         if (i == 5) begin
            value    = 20'h00999;
            dec_mode = 1'b0;
            load     = 1'b1;
         end
         if (i == 6) load = 1'b0;
         if (done === 1'b1) begin
            pulses++;
            snap_seg = seg;
         end
         @(negedge mem_clk);
      end
      check("busy_load_pulses", pulses, 1);
      check("busy_load_seg", snap_seg, {G1, G2, G3, G4, G5, G6});
      check("busy_load_idle", busy, 1'b0);

      // Reset in the middle of a conversion.
      apply_stimulus(20'd654321, 1'b1, 1'b0);
      pulses = 0;
      repeat (10) begin
         if (done === 1'b1) pulses++;
         @(negedge mem_clk);
      end
      check("abort_busy_before", busy, 1'b1);
      resetn = 1'b0;
      @(negedge mem_clk);
      check("abort_seg", seg, {42{1'b1}});
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      resetn = 1'b1;
      repeat (25) begin
         if (done === 1'b1) pulses++;
         @(negedge mem_clk);
      end
      check("abort_no_done", pulses, 0);
      check("abort_seg_held", seg, {42{1'b1}});

      apply_stimulus(20'h00012, 1'b0, 1'b1);
      check_output("after_abort_hex", {BL, BL, BL, BL, G1, G2}, 1'b0, 1);

      apply_stimulus(20'd300, 1'b1, 1'b1);
      check_output("after_abort_dec", {BL, BL, BL, G3, G0, G0}, 1'b0, 21);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
